// File: rtl/adc_bar_display.sv
// Four-channel ADC bar-graph driver for a multiplexed 8x4 LED matrix.
// Each column slot starts blanked, samples its channel, then shows a bar with a decaying peak dot.
module adc_bar_display #(
   parameter int SCAN_TICKS       = 3000,
   parameter int BLANK_TICKS      = 12,
   parameter int PEAK_HOLD_FRAMES = 256
) (
   input  logic       clock12MHz,
   input  logic       reset,
   input  logic [9:0] value1,
   input  logic [9:0] value2,
   input  logic [9:0] value3,
   input  logic [9:0] value4,
   output logic [7:0] leds,
   output logic [3:0] lcol,
   output logic       frameStart
);

   localparam int TW = $clog2(SCAN_TICKS);
   localparam int HW = (PEAK_HOLD_FRAMES > 1) ? $clog2(PEAK_HOLD_FRAMES) : 1;
   localparam logic [TW-1:0] TICK_LAST  = TW'(SCAN_TICKS - 1);
   localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);
   localparam logic [HW-1:0] HOLD_LAST  = HW'(PEAK_HOLD_FRAMES - 1);

   typedef enum logic {ST_BLANK, ST_SHOW} state_t;

   state_t          r_state, w_state_nxt;
   logic [TW-1:0]   r_tick, w_tick_nxt;
   logic [1:0]      r_col, w_col_nxt;
   logic            r_run;
   logic            w_sample;

   logic [3:0]      r_peak    [4];
   logic [HW-1:0]   r_hold    [4];
   logic [7:0]      r_pattern [4];
   logic [7:0]      r_leds;
   logic [3:0]      r_lcol;
   logic            r_frame;

   logic [9:0]      w_value;
   logic [10:0]     w_sum;
   logic [3:0]      w_level;
   logic [7:0]      w_bar;
   logic [3:0]      w_peak_new;
   logic [HW-1:0]   w_hold_new;
   logic [7:0]      w_dot;
   logic [7:0]      w_pattern_new;
   logic [7:0]      w_show_pat;
   logic [7:0]      w_leds_nxt;
   logic [3:0]      w_lcol_nxt;
   logic            w_frame_nxt;

   // r_run holds the counters at column 0 tick 0 for one cycle after reset so that cycle carries frameStart.
   always_comb begin
      w_state_nxt = r_state;
      w_tick_nxt  = r_tick;
      w_col_nxt   = r_col;
      w_sample    = 1'b0;
      if (!r_run) begin
         w_state_nxt = ST_BLANK;
         w_tick_nxt  = '0;
         w_col_nxt   = '0;
      end else if (r_tick == TICK_LAST) begin
         w_state_nxt = ST_BLANK;
         w_tick_nxt  = '0;
         w_col_nxt   = r_col + 2'd1;
      end else begin
         w_tick_nxt = r_tick + TW'(1);
         if (r_state == ST_BLANK && r_tick == BLANK_LAST) begin
            w_state_nxt = ST_SHOW;
            w_sample    = 1'b1;
         end
      end
   end

   always_ff @(posedge clock12MHz) begin
      if (reset) begin
         r_state <= ST_BLANK;
         r_tick  <= '0;
         r_col   <= '0;
         r_run   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_tick  <= w_tick_nxt;
         r_col   <= w_col_nxt;
         r_run   <= 1'b1;
      end
   end

   always_comb begin
      w_value = value1;
      case (r_col)
         2'd0: w_value = value1;
         2'd1: w_value = value2;
         2'd2: w_value = value3;
         2'd3: w_value = value4;
         default: w_value = value1;
      endcase
      w_sum   = {1'b0, w_value} + 11'd127;
      w_level = 4'(w_sum >> 7);
      w_bar   = '0;
      for (int i = 0; i < 8; i++) begin
         w_bar[i] = (4'(i) < w_level);
      end

      w_peak_new = r_peak[r_col];
      w_hold_new = r_hold[r_col];
      if (w_level >= r_peak[r_col]) begin
         w_peak_new = w_level;
         w_hold_new = '0;
      end else if (r_hold[r_col] == HOLD_LAST) begin
         w_peak_new = r_peak[r_col] - 4'd1;
         w_hold_new = '0;
      end else begin
         w_hold_new = r_hold[r_col] + HW'(1);
      end

      w_dot         = (w_peak_new != 4'd0) ? (8'd1 << (w_peak_new - 4'd1)) : 8'd0;
      w_pattern_new = w_bar | w_dot;

      // On the sample edge the freshly computed pattern goes straight to the pins.
      w_show_pat  = w_sample ? w_pattern_new : r_pattern[w_col_nxt];
      w_lcol_nxt  = (w_state_nxt == ST_SHOW) ? ~(4'b0001 << w_col_nxt) : 4'hF;
      w_leds_nxt  = (w_state_nxt == ST_SHOW) ? ~w_show_pat : 8'hFF;
      w_frame_nxt = (w_col_nxt == 2'd0) && (w_tick_nxt == '0);
   end

   always_ff @(posedge clock12MHz) begin
      if (reset) begin
         for (int c = 0; c < 4; c++) begin
            r_peak[c]    <= '0;
            r_hold[c]    <= '0;
            r_pattern[c] <= '0;
         end
         r_leds  <= 8'hFF;
         r_lcol  <= 4'hF;
         r_frame <= 1'b0;
      end else begin
         if (w_sample) begin
            r_peak[r_col]    <= w_peak_new;
            r_hold[r_col]    <= w_hold_new;
            r_pattern[r_col] <= w_pattern_new;
         end
         r_leds  <= w_leds_nxt;
         r_lcol  <= w_lcol_nxt;
         r_frame <= w_frame_nxt;
      end
   end

   assign leds       = r_leds;
   assign lcol       = r_lcol;
   assign frameStart = r_frame;

endmodule

// File: tb/tb_adc_bar_display.sv
// Bench for adc_bar_display: cycle-level reference model of slots, sampling and peak decay,
// plus directed checks of reset, bars, decay, sample timing, mid-frame reset and framing.
module tb_adc_bar_display;

   localparam int S   = 20;
   localparam int B   = 4;
   localparam int PHF = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] val [4];
   logic [7:0] leds;
   logic [3:0] lcol;
   logic       fs;

   always #5 clk = ~clk;

   adc_bar_display #(.SCAN_TICKS(S), .BLANK_TICKS(B), .PEAK_HOLD_FRAMES(PHF)) dut (
      .clock12MHz (clk),
      .reset      (rst),
      .value1     (val[0]),
      .value2     (val[1]),
      .value3     (val[2]),
      .value4     (val[3]),
      .leds       (leds),
      .lcol       (lcol),
      .frameStart (fs)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // model: m_cyc counts cycles since the frame start that follows reset release (-1 = not running)
   int         m_cyc;
   int         m_peak [4];
   int         m_hold [4];
   logic [7:0] m_pat  [4];

   logic [3:0] bar_lcol [4];
   logic [7:0] bar_leds [4];
   logic [7:0] decay    [17];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int cur_col();
      return (m_cyc / S) % 4;
   endfunction

   function automatic int cur_tick();
      return m_cyc % S;
   endfunction

   task automatic model_reset();
      m_cyc = -1;
      for (int c = 0; c < 4; c++) begin
         m_peak[c] = 0;
         m_hold[c] = 0;
         m_pat[c]  = 8'h00;
      end
   endtask

   task automatic model_sample(input int c);
      int lvl;
      logic [7:0] p;
      lvl = (int'(val[c]) + 127) / 128;
      if (lvl >= m_peak[c]) begin
         m_peak[c] = lvl;
         m_hold[c] = 0;
      end else if (m_hold[c] == PHF - 1) begin
         m_peak[c] = m_peak[c] - 1;
         m_hold[c] = 0;
      end else begin
         m_hold[c] = m_hold[c] + 1;
      end
      p = 8'h00;
      for (int r = 0; r < 8; r++) begin
         if (r < lvl || r == m_peak[c] - 1) p[r] = 1'b1;
      end
      m_pat[c] = p;
   endtask

   task automatic step();
      logic [3:0] e_lcol;
      logic [7:0] e_leds;
      logic       e_fs;
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         if (m_cyc >= 0 && cur_tick() == B - 1) model_sample(cur_col());
         m_cyc++;
      end
      #1;
      e_lcol = 4'hF;
      e_leds = 8'hFF;
      e_fs   = 1'b0;
      if (m_cyc >= 0) begin
         e_fs = (m_cyc % (4 * S) == 0);
         if (cur_tick() >= B) begin
            e_lcol = 4'hF ^ (4'b0001 << cur_col());
            e_leds = ~m_pat[cur_col()];
         end
      end
      chk("model_lcol", 32'(lcol), 32'(e_lcol));
      chk("model_leds", 32'(leds), 32'(e_leds));
      chk("model_frameStart", 32'(fs), 32'(e_fs));
   endtask

   task automatic run_to(input int col, input int tick);
      for (int i = 0; i < 200; i++) begin
         step();
         if (m_cyc >= 0 && cur_col() == col && cur_tick() == tick) return;
      end
      n_assert++;
      n_fail++;
      $error("FAIL run_to: observed timeout expected col %0d tick %0d", col, tick);
   endtask

   task automatic set_all(input logic [9:0] v);
      for (int c = 0; c < 4; c++) val[c] = v;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      int last_fs;
      int n_frames;
      bar_lcol = '{4'hE, 4'hD, 4'hB, 4'h7};
      bar_leds = '{8'hFF, 8'hFE, 8'hF0, 8'h00};
      decay    = '{8'h00, 8'h7F, 8'hBF, 8'hBF, 8'hDF, 8'hDF, 8'hEF, 8'hEF, 8'hF7,
                   8'hF7, 8'hFB, 8'hFB, 8'hFD, 8'hFD, 8'hFE, 8'hFE, 8'hFF};
      model_reset();
      rst = 1'b1;
      set_all(10'd1023);

      // reset held three cycles, then four blank cycles after release
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_lcol", 32'(lcol), 32'h0F);
         chk("rst_leds", 32'(leds), 32'hFF);
      end
      rst = 1'b0;
      step();
      chk("release_frameStart", 32'(fs), 32'h1);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) step();
         chk("release_blank_lcol", 32'(lcol), 32'h0F);
         chk("release_blank_leds", 32'(leds), 32'hFF);
      end
      step();
      chk("first_show_lcol", 32'(lcol), 32'h0E);
      chk("first_show_leds", 32'(leds), 32'h00);

      // bars of four distinct heights
      val[0] = 10'd0; val[1] = 10'd128; val[2] = 10'd512; val[3] = 10'd1023;
      pulse_reset();
      for (int c = 0; c < 4; c++) begin
         run_to(c, 10);
         chk("bars_lcol", 32'(lcol), 32'(bar_lcol[c]));
         chk("bars_leds", 32'(leds), 32'(bar_leds[c]));
      end

      // peak hold and decay on column 0
      set_all(10'd0);
      val[0] = 10'd1023;
      pulse_reset();
      run_to(0, 5);
      val[0] = 10'd0;
      for (int f = 0; f < 17; f++) begin
         run_to(0, 10);
         chk("decay_leds", 32'(leds), 32'(decay[f]));
      end

      // input change after the sample edge waits for the next slot
      set_all(10'd0);
      pulse_reset();
      run_to(1, 10);
      val[1] = 10'd1023;
      run_to(1, 11);
      chk("late_change_leds", 32'(leds), 32'hFF);
      run_to(1, 19);
      chk("late_change_end_leds", 32'(leds), 32'hFF);
      run_to(1, 10);
      chk("next_frame_leds", 32'(leds), 32'h00);

      // reset in the middle of a show slot
      set_all(10'd1023);
      pulse_reset();
      run_to(3, 19);
      run_to(2, 12);
      rst = 1'b1;
      set_all(10'd0);
      step();
      chk("midreset_lcol", 32'(lcol), 32'h0F);
      chk("midreset_leds", 32'(leds), 32'hFF);
      chk("midreset_frameStart", 32'(fs), 32'h0);
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         run_to(c, 10);
         chk("after_reset_leds", 32'(leds), 32'hFF);
      end

      // free run with random inputs: frame period and column order
      pulse_reset();
      last_fs  = -1;
      n_frames = 0;
      for (int i = 0; i < 5 * 4 * S; i++) begin
         if (i > 0) step();
         if (fs) begin
            if (last_fs >= 0) chk("frame_period", 32'(i - last_fs), 32'(4 * S));
            last_fs = i;
            n_frames++;
         end
         if (m_cyc >= 0 && cur_tick() == 10) chk("frame_lcol", 32'(lcol), 32'(bar_lcol[cur_col()]));
         if ($urandom_range(0, 7) == 0) val[$urandom_range(0, 3)] = 10'($urandom_range(0, 1023));
      end
      chk("frame_count", 32'(n_frames), 32'd5);

      // random values with occasional resets at arbitrary points
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 3) == 0) val[$urandom_range(0, 3)] = 10'($urandom_range(0, 1023));
         if ($urandom_range(0, 3) == 0) val[$urandom_range(0, 3)] = ($urandom_range(0, 1) == 1) ? 10'd1023 : 10'd0;
         rst = ($urandom_range(0, 199) == 0);
         step();
      end
      rst = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
